// File: rtl/huffman_mcu_scheduler.sv
// Walks the MCU slot order (Y x Y_PER_MCU, Cb, Cr), hands each block to the shared
// Huffman encoder controller with its DC difference and table select, and acks the requester.
module huffman_mcu_scheduler #(
  parameter int Y_PER_MCU    = 1,
  parameter int GRAYSCALE    = 0,
  parameter int RESTART_MCUS = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         y_req,
  input  logic [511:0] y_block,
  output logic         y_ack,
  input  logic         cb_req,
  input  logic [511:0] cb_block,
  output logic         cb_ack,
  input  logic         cr_req,
  input  logic [511:0] cr_block,
  output logic         cr_ack,
  output logic         huff_start,
  output logic [511:0] huff_block,
  output logic [8:0]   huff_dc_diff,
  output logic         huff_chroma,
  input  logic         huff_done,
  output logic         busy,
  output logic         mcu_done,
  output logic         restart_pulse,
  output logic [15:0]  mcu_count
);

  localparam logic [2:0]  LAST_SLOT    = 3'(Y_PER_MCU - 1 + 2 * (1 - GRAYSCALE));
  localparam logic [2:0]  CB_SLOT      = 3'(Y_PER_MCU);
  localparam logic [15:0] RESTART_LAST = 16'(RESTART_MCUS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REQ, S_START, S_WAIT_DONE, S_ACK, S_MCU_END, S_RESTART
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    slot_reg;
  logic [7:0]    pred_reg [3];
  logic [15:0]   interval_reg;
  logic [15:0]   mcu_count_reg;
  logic [511:0]  huff_block_reg;
  logic [8:0]    huff_dc_diff_reg;
  logic          huff_chroma_reg;

  logic [1:0]    comp;
  logic          cur_req;
  logic [511:0]  cur_block;
  logic [7:0]    cur_pred;
  logic          accept;
  logic          restart_hit;

  // Component served by the current slot: 0 = Y, 1 = Cb, 2 = Cr
  always_comb begin
    comp      = 2'd0;
    cur_req   = y_req;
    cur_block = y_block;
    cur_pred  = pred_reg[0];
    if (slot_reg == CB_SLOT) begin
      comp      = 2'd1;
      cur_req   = cb_req;
      cur_block = cb_block;
      cur_pred  = pred_reg[1];
    end else if (slot_reg > CB_SLOT) begin
      comp      = 2'd2;
      cur_req   = cr_req;
      cur_block = cr_block;
      cur_pred  = pred_reg[2];
    end
  end

  assign accept      = (state_reg == S_WAIT_REQ) && cur_req;
  assign restart_hit = (RESTART_MCUS != 0) && (interval_reg == RESTART_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (enable) state_next = S_WAIT_REQ;
      S_WAIT_REQ:  if (cur_req) state_next = S_START;
      S_START:     state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (huff_done) state_next = S_ACK;
      S_ACK:       state_next = (slot_reg == LAST_SLOT) ? S_MCU_END : S_WAIT_REQ;
      S_MCU_END:   state_next = restart_hit ? S_RESTART : S_IDLE;
      S_RESTART:   state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    huff_start    = (state_reg == S_START);
    busy          = (state_reg != S_IDLE);
    mcu_done      = (state_reg == S_MCU_END);
    restart_pulse = (state_reg == S_RESTART);
    y_ack         = (state_reg == S_ACK) && (comp == 2'd0);
    cb_ack        = (state_reg == S_ACK) && (comp == 2'd1);
    cr_ack        = (state_reg == S_ACK) && (comp == 2'd2);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_reg         <= '0;
      interval_reg     <= '0;
      mcu_count_reg    <= '0;
      huff_block_reg   <= '0;
      huff_dc_diff_reg <= '0;
      huff_chroma_reg  <= 1'b0;
      for (int i = 0; i < 3; i++) pred_reg[i] <= '0;
    end else begin
      if (accept) begin
        // DC range -128..127 makes the 9-bit difference exact, no saturation needed
        huff_block_reg   <= cur_block;
        huff_dc_diff_reg <= {cur_block[7], cur_block[7:0]} - {cur_pred[7], cur_pred};
        huff_chroma_reg  <= (comp != 2'd0);
        pred_reg[comp]   <= cur_block[7:0];
      end
      if (state_reg == S_ACK && slot_reg != LAST_SLOT) slot_reg <= slot_reg + 3'd1;
      if (state_reg == S_MCU_END) begin
        slot_reg      <= '0;
        mcu_count_reg <= mcu_count_reg + 16'd1;
        interval_reg  <= restart_hit ? 16'd0 : interval_reg + 16'd1;
      end
      if (state_reg == S_RESTART) begin
        for (int i = 0; i < 3; i++) pred_reg[i] <= '0;
      end
    end
  end

  assign huff_block   = huff_block_reg;
  assign huff_dc_diff = huff_dc_diff_reg;
  assign huff_chroma  = huff_chroma_reg;
  assign mcu_count    = mcu_count_reg;

endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// Directed bench for huffman_mcu_scheduler: three instances cover 4:4:4, 4:2:0 (four Y)
// and grayscale with a two-MCU restart interval.
module tb_huffman_mcu_scheduler;

  logic         clock;
  logic         reset_n;
  logic         enable [3];
  logic         req [3][3];
  logic [511:0] blk [3][3];
  logic         ack [3][3];
  logic         huff_start [3];
  logic [511:0] huff_block [3];
  logic [8:0]   huff_dc_diff [3];
  logic         huff_chroma [3];
  logic         huff_done [3];
  logic         busy [3];
  logic         mcu_done [3];
  logic         restart_pulse [3];
  logic [15:0]  mcu_count [3];

  int checks = 0;
  int errors = 0;
  int mcu_done_cnt [3];
  int restart_cnt [3];
  int ack_cnt [3][3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    huffman_mcu_scheduler #(
      .Y_PER_MCU   ((gi == 1) ? 4 : 1),
      .GRAYSCALE   ((gi == 2) ? 1 : 0),
      .RESTART_MCUS((gi == 2) ? 2 : 0)
    ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable[gi]),
      .y_req        (req[gi][0]),
      .y_block      (blk[gi][0]),
      .y_ack        (ack[gi][0]),
      .cb_req       (req[gi][1]),
      .cb_block     (blk[gi][1]),
      .cb_ack       (ack[gi][1]),
      .cr_req       (req[gi][2]),
      .cr_block     (blk[gi][2]),
      .cr_ack       (ack[gi][2]),
      .huff_start   (huff_start[gi]),
      .huff_block   (huff_block[gi]),
      .huff_dc_diff (huff_dc_diff[gi]),
      .huff_chroma  (huff_chroma[gi]),
      .huff_done    (huff_done[gi]),
      .busy         (busy[gi]),
      .mcu_done     (mcu_done[gi]),
      .restart_pulse(restart_pulse[gi]),
      .mcu_count    (mcu_count[gi])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (mcu_done[i] === 1'b1) mcu_done_cnt[i]++;
      if (restart_pulse[i] === 1'b1) restart_cnt[i]++;
      for (int c = 0; c < 3; c++) if (ack[i][c] === 1'b1) ack_cnt[i][c]++;
    end
  end

  // Present one block, wait for its start, check the encoder-side outputs, finish it, check the ack
  task automatic serve(input int i, input int c, input logic [7:0] dc, input logic [8:0] exp_diff,
                       input bit keep, input string nm);
    logic [511:0] b;
    logic [31:0]  seed;
    logic [2:0]   acks, exp_acks;
    int n;
    seed = $urandom();
    b = {16{seed}};
    b[7:0] = dc;
    blk[i][c] = b;
    req[i][c] = 1'b1;
    n = 0;
    while (huff_start[i] !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (huff_start[i] !== 1'b1) begin
      errors++;
      $display("FAIL %s start_timeout: huff_start=%b required 1", nm, huff_start[i]);
      req[i][c] = keep;
      return;
    end
    checks++;
    if (huff_dc_diff[i] !== exp_diff) begin
      errors++;
      $display("FAIL %s dc_diff: got %0d required %0d", nm, $signed(huff_dc_diff[i]), $signed(exp_diff));
    end
    checks++;
    if (huff_chroma[i] !== (c != 0)) begin
      errors++;
      $display("FAIL %s chroma: got %b required %b", nm, huff_chroma[i], (c != 0));
    end
    checks++;
    if (huff_block[i] !== b) begin
      errors++;
      $display("FAIL %s block: got low %h required low %h", nm, huff_block[i][63:0], b[63:0]);
    end
    @(negedge clock);
    huff_done[i] = 1'b1;
    @(negedge clock);
    huff_done[i] = 1'b0;
    acks = {ack[i][2], ack[i][1], ack[i][0]};
    exp_acks = 3'b001 << c;
    checks++;
    if (acks !== exp_acks) begin
      errors++;
      $display("FAIL %s ack: got cr/cb/y=%b required %b", nm, acks, exp_acks);
    end
    $display("blk %s inst=%0d comp=%0d dc=%0d diff=%0d", nm, i, c, $signed(dc), $signed(huff_dc_diff[i]));
    if (!keep) req[i][c] = 1'b0;
  endtask

  task automatic check_mcu_end(input int i, input logic [15:0] exp_count, input string nm);
    @(negedge clock);
    checks++;
    if (mcu_done[i] !== 1'b1) begin
      errors++;
      $display("FAIL %s mcu_done: got %b required 1", nm, mcu_done[i]);
    end
    @(negedge clock);
    checks++;
    if (mcu_count[i] !== exp_count) begin
      errors++;
      $display("FAIL %s mcu_count: got %0d required %0d", nm, mcu_count[i], exp_count);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || huff_start[i] !== 1'b0 || mcu_count[i] !== 16'd0 ||
          huff_block[i] !== '0 || huff_dc_diff[i] !== 9'd0) begin
        errors++;
        $display("FAIL reset inst%0d: busy=%b start=%b count=%0d diff=%0d required all 0",
                 i, busy[i], huff_start[i], mcu_count[i], huff_dc_diff[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b required 0 with enable low", busy[0]);
    end
    $display("reset done");
  endtask

  task automatic test_444();
    enable[0] = 1'b1;
    serve(0, 0, 8'd10,  9'd10,   1'b0, "m1_y");
    serve(0, 1, 8'hFD,  9'h1FD,  1'b0, "m1_cb");
    serve(0, 2, 8'd0,   9'd0,    1'b0, "m1_cr");
    check_mcu_end(0, 16'd1, "m1");
    serve(0, 0, 8'd20,  9'd10,   1'b0, "m2_y");
    serve(0, 1, 8'hFD,  9'd0,    1'b0, "m2_cb");
    serve(0, 2, 8'd127, 9'd127,  1'b0, "m2_cr");
    check_mcu_end(0, 16'd2, "m2");
    serve(0, 0, 8'd5,   9'h1F1,  1'b0, "m3_y");
    serve(0, 1, 8'd4,   9'd7,    1'b0, "m3_cb");
    serve(0, 2, 8'h80,  9'h101,  1'b0, "m3_cr");
    check_mcu_end(0, 16'd3, "m3");
  endtask

  task automatic test_spurious();
    int bad;
    bad = 0;
    blk[0][2] = {504'd0, 8'd100};
    req[0][2] = 1'b1;
    @(negedge clock);
    huff_done[0] = 1'b1;
    @(negedge clock);
    huff_done[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ack[0][0] || ack[0][1] || ack[0][2] || huff_start[0] || !busy[0]) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL spurious: %0d cycles with ack/start/idle, required 0", bad);
    end
    serve(0, 0, 8'd5,   9'd0,   1'b0, "m4_y");
    serve(0, 1, 8'd4,   9'd0,   1'b0, "m4_cb");
    serve(0, 2, 8'd100, 9'd228, 1'b0, "m4_cr");
    check_mcu_end(0, 16'd4, "m4");
  endtask

  task automatic test_mcu4();
    blk[1][1] = '0;
    blk[1][2] = '0;
    req[1][1] = 1'b1;
    req[1][2] = 1'b1;
    enable[1] = 1'b1;
    serve(1, 0, 8'd4,  9'd4,   1'b1, "q_y0");
    serve(1, 0, 8'hFC, 9'h1F8, 1'b1, "q_y1");
    serve(1, 0, 8'd4,  9'd8,   1'b1, "q_y2");
    serve(1, 0, 8'd7,  9'd3,   1'b1, "q_y3");
    serve(1, 1, 8'd2,  9'd2,   1'b1, "q_cb");
    serve(1, 2, 8'hFF, 9'h1FF, 1'b1, "q_cr");
    @(negedge clock);
    enable[1] = 1'b0;
    for (int c = 0; c < 3; c++) req[1][c] = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (mcu_done_cnt[1] !== 1) begin
      errors++;
      $display("FAIL q_mcu_done_count: got %0d required 1", mcu_done_cnt[1]);
    end
    checks++;
    if (ack_cnt[1][0] !== 4 || ack_cnt[1][1] !== 1 || ack_cnt[1][2] !== 1) begin
      errors++;
      $display("FAIL q_ack_counts: got y=%0d cb=%0d cr=%0d required 4 1 1",
               ack_cnt[1][0], ack_cnt[1][1], ack_cnt[1][2]);
    end
  endtask

  task automatic test_gray_restart();
    blk[2][1] = '1;
    blk[2][2] = '1;
    req[2][1] = 1'b1;
    req[2][2] = 1'b1;
    enable[2] = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      serve(2, 0, 8'd50, (m % 2 == 1) ? 9'd50 : 9'd0, 1'b0, "g_y");
      @(negedge clock);
      checks++;
      if (mcu_done[2] !== 1'b1) begin
        errors++;
        $display("FAIL g_mcu_done m%0d: got %b required 1", m, mcu_done[2]);
      end
      if (m == 4) enable[2] = 1'b0;
      @(negedge clock);
      checks++;
      if (restart_pulse[2] !== (m % 2 == 0)) begin
        errors++;
        $display("FAIL g_restart m%0d: got %b required %b", m, restart_pulse[2], (m % 2 == 0));
      end
    end
    repeat (3) @(negedge clock);
    req[2][1] = 1'b0;
    req[2][2] = 1'b0;
    checks++;
    if (ack_cnt[2][1] !== 0 || ack_cnt[2][2] !== 0 || restart_cnt[2] !== 2 || mcu_count[2] !== 16'd4) begin
      errors++;
      $display("FAIL g_totals: cb_ack=%0d cr_ack=%0d restarts=%0d count=%0d required 0 0 2 4",
               ack_cnt[2][1], ack_cnt[2][2], restart_cnt[2], mcu_count[2]);
    end
  endtask

  task automatic test_reset_mid_block();
    int n;
    int acks_before;
    blk[0][0] = {504'd7, 8'd33};
    req[0][0] = 1'b1;
    n = 0;
    while (huff_start[0] !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    acks_before = ack_cnt[0][0] + ack_cnt[0][1] + ack_cnt[0][2];
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || huff_block[0] !== '0 || huff_dc_diff[0] !== 9'd0 || huff_chroma[0] !== 1'b0 ||
        mcu_count[0] !== 16'd0 || ack[0][0] !== 1'b0 || huff_start[0] !== 1'b0 ||
        mcu_done[0] !== 1'b0 || restart_pulse[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b diff=%0d count=%0d block_lo=%h required all 0",
               busy[0], huff_dc_diff[0], mcu_count[0], huff_block[0][63:0]);
    end
    req[0][0] = 1'b0;
    huff_done[0] = 1'b1;
    repeat (3) @(negedge clock);
    huff_done[0] = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (ack_cnt[0][0] + ack_cnt[0][1] + ack_cnt[0][2] !== acks_before) begin
      errors++;
      $display("FAIL mid_reset_ack: %0d acks after reset, required 0",
               ack_cnt[0][0] + ack_cnt[0][1] + ack_cnt[0][2] - acks_before);
    end
    serve(0, 0, 8'd9, 9'd9, 1'b0, "post_reset_y");
    enable[0] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable[i] = 1'b0;
      huff_done[i] = 1'b0;
      mcu_done_cnt[i] = 0;
      restart_cnt[i] = 0;
      for (int c = 0; c < 3; c++) begin
        req[i][c] = 1'b0;
        blk[i][c] = '0;
        ack_cnt[i][c] = 0;
      end
    end
    test_reset();
    test_444();
    test_spurious();
    test_mcu4();
    test_gray_restart();
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
